axi_lite_master_if: RTL
=======================

Name: axi_lite_master_if

Overview:
Single-outstanding AXI-Lite master. Converts a simple command/response handshake into AXI-Lite 5-channel transactions. It is the initiator counterpart of the block's AXI-Lite slave register port, and is used by the test/debug sequencer and the host-bridge to access the UART register map. Each transaction has a completion timeout so a hung slave cannot lock up the requester.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 supported
ADDR_WIDTH, 32, AXI byte-address width
TIMEOUT_CYCLES, 256, cycles from command accept to AXI completion before abort; 0 disables timeout

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  AXI response code (00 OKAY, 10 SLVERR, 11 DECERR)
rsp_timeout  out  1  transaction aborted by timeout
busy  out  1  state != IDLE
awaddr/awvalid out, awready in  AXI write address channel
wdata/wstrb/wvalid out, wready in  AXI write data channel
bresp/bvalid in, bready out  AXI write response channel
araddr/arvalid out, arready in  AXI read address channel
rdata/rresp/rvalid in, rready out  AXI read data channel

Behaviour:
- Reset (async, rst_n low): state IDLE. All valid/ready outputs 0. Address, data and rsp_* registers 0. rsp_timeout 0. Reset mid-transaction drops all valids immediately; nothing is retried.
- cmd_ready = (state == IDLE), combinational. At most one transaction is outstanding.
- States: IDLE, WRITE, WR_RESP, READ, RD_DATA, RSP.
- IDLE, on accept:
  - Register addr, wdata and wstrb, unmodified.
  - Clear the timeout counter.
  - Go to WRITE or READ. awvalid+wvalid, or arvalid, are registered high in the cycle after accept (1-cycle issue latency).
- WRITE:
  - awvalid and wvalid are dropped independently on their own handshake. Tracking flags aw_done and w_done allow either order, including the same cycle.
  - Valids and payload stay stable until their handshake.
  - When both are done, go to WR_RESP.
- WR_RESP: bready = 1 (registered on entry). On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, drop bready, go to RSP.
- READ: arvalid held with stable araddr until arready, then drop arvalid and go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rdata and rresp, drop rready, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* are held stable until rsp_ready, then return to IDLE.
  - A new command can be accepted the cycle after rsp_valid && rsp_ready.
- Timeout counter:
  - Increments each cycle in WRITE/WR_RESP/READ/RD_DATA and saturates.
  - If it reaches TIMEOUT_CYCLES (nonzero), abort: all AXI valid/ready outputs drop next cycle, rsp_resp = 10, rsp_rdata = 0, rsp_timeout = 1, go to RSP.
  - The abort is a deliberate recovery action that breaks AXI valid-stability. It is logged by the requester and not counted as a protocol violation.
  - A completion in the same cycle the counter hits the limit wins: the response is normal and rsp_timeout = 0.
- rsp_timeout is cleared on the next command accept.
- Unsolicited bvalid/rvalid outside WR_RESP/RD_DATA are ignored, since bready/rready are 0 there.

Test Plan:
1. Write 0x0000_0008 / 0xA5A5_00FF / wstrb 0xF; slave raises awready+wready one cycle after valid, then bvalid with bresp 00 -> awvalid/wvalid high from cycle 1, bready high in WR_RESP, rsp_valid with rsp_resp 00, rsp_rdata 0, rsp_timeout 0.
2. Write where wready comes 3 cycles before awready -> wvalid drops right after its handshake, awvalid stays high with stable awaddr until awready, exactly one B handshake, rsp_resp 00.
3. Read 0x0000_0004; slave returns rdata 0x0000_1234, rresp 00 after 2 cycles -> arvalid drops after arready, rready high, rsp_rdata 0x0000_1234, rsp_resp 00.
4. Read with rresp 10; hold rsp_ready low 5 cycles -> rsp_valid, rsp_resp 10 and rsp_rdata stay stable, cmd_ready stays 0 until rsp_ready, then IDLE.
5. TIMEOUT_CYCLES = 16, slave never asserts arready -> after 16 cycles arvalid drops, rsp_resp 10, rsp_timeout 1; the next command clears rsp_timeout.
6. Assert rst_n low while awvalid is high in WRITE -> all outputs 0 immediately, state IDLE, cmd_ready 1 after release; a subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// Single-outstanding AXI-Lite master.
// Turns a command/response handshake into one AXI-Lite read or write at a
// time, with a completion timeout so a hung slave cannot stall the requester.
`timescale 1ns/1ps

module axi_lite_master_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // command side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response side
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    busy,
  // AXI write address
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI write response
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI read address
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WR_RESP,
    S_READ,
    S_RD_DATA,
    S_RSP
  } state_t;

  // The timer only has to reach TIMEOUT_CYCLES-1: the abort fires in the
  // cycle the timer holds that value, so the channel was driven for exactly
  // TIMEOUT_CYCLES cycles when the outputs drop.
  localparam int            TW          = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit            TIMEOUT_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  aw_done;
  logic                  w_done;
  logic [TW-1:0]         timer;

  logic accept;
  logic active;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic b_done;
  logic r_done;
  logic timeout_hit;
  logic abort;

  assign accept = cmd_valid && cmd_ready;
  assign active = (state == S_WRITE) || (state == S_WR_RESP) ||
                  (state == S_READ)  || (state == S_RD_DATA);
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign b_done = (state == S_WR_RESP) && bvalid;
  assign r_done = (state == S_RD_DATA) && rvalid;

  // A real completion in the limit cycle takes priority over the abort.
  assign timeout_hit = TIMEOUT_EN && active && (timer == TIMER_LIMIT);
  assign abort       = timeout_hit && !b_done && !r_done;

  assign awaddr = addr_q;
  assign araddr = addr_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is always updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // variable unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      S_IDLE:    if (accept) state_next = cmd_write ? S_WRITE : S_READ;
      S_WRITE: begin
        if (abort)                                          state_next = S_RSP;
        else if ((aw_done || aw_hs) && (w_done || w_hs))    state_next = S_WR_RESP;
      end
      S_WR_RESP: if (b_done || abort) state_next = S_RSP;
      S_READ: begin
        if (abort)      state_next = S_RSP;
        else if (ar_hs) state_next = S_RD_DATA;
      end
      S_RD_DATA: if (r_done || abort) state_next = S_RSP;
      S_RSP:     if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state, so each one rises
  // the cycle after the transition that enables it and drops on reset at once.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WRITE: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      S_WR_RESP: bready    = 1'b1;
      S_READ:    arvalid   = 1'b1;
      S_RD_DATA: rready    = 1'b1;
      S_RSP:     rsp_valid = 1'b1;
      default:   busy      = 1'b1;
    endcase
  end

  // Datapath: command capture, channel-done flags, timeout timer and
  // response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      timer       <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else if (accept) begin
      addr_q      <= cmd_addr;
      wdata       <= cmd_wdata;
      wstrb       <= cmd_wstrb;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      timer       <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (active && !(&timer)) timer <= timer + 1'b1;
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;

      if (b_done) begin
        rsp_resp  <= bresp;
        rsp_rdata <= '0;
      end else if (r_done) begin
        rsp_resp  <= rresp;
        rsp_rdata <= rdata;
      end else if (abort) begin
        rsp_resp    <= RESP_SLVERR;
        rsp_rdata   <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
